// File: rtl/yadan_spi_slave_pkg.sv
// yadan_spi_slave_pkg: shared state encoding and defaults for the SPI responder
package yadan_spi_slave_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    localparam int          DEF_DATA_WIDTH  = 8;
    localparam int          DEF_SYNC_STAGES = 2;
    localparam logic [31:0] DEF_IDLE_WORD   = 32'hFF;

endpackage

// File: rtl/yadan_spi_slave_sync_edge.sv
// yadan_spi_slave_sync_edge: multi-flop synchronizer with rise/fall pulses on its last two flops
module yadan_spi_slave_sync_edge
    import yadan_spi_slave_pkg::*;
#(
    parameter int   STAGES    = DEF_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES:0] sync;

    // shift the raw input through the synchronizer plus one edge-reference flop
    always_ff @(posedge clk) begin
        if (!rst) sync <= {(STAGES + 1){RESET_VAL}};
        else      sync <= {sync[STAGES-1:0], d};
    end

    assign rise = sync[STAGES-1] & ~sync[STAGES];
    assign fall = ~sync[STAGES-1] & sync[STAGES];

endmodule

// File: rtl/yadan_spi_slave.sv
// yadan_spi_slave: oversampling SPI mode-0 responder with tx holding register and rx output register
module yadan_spi_slave
    import yadan_spi_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                    SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = DATA_WIDTH'(DEF_IDLE_WORD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_scs,
    input  logic                  spi_sdi,
    output logic                  spi_sdo,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    spi_state_t            state, next;
    logic                  sck_rise, sck_fall, scs_rise, scs_fall;
    logic [SYNC_STAGES-1:0] sdi_sr;
    logic                  sdi_sync;
    logic [CW-1:0]         cnt;
    logic                  last;
    logic                  load, bit_in, shift_out, abort;
    logic [DATA_WIDTH-2:0] shift_rx;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [DATA_WIDTH-1:0] shifter;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_full;
    logic                  write;

    yadan_spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
        .clk  (clk),
        .rst  (rst),
        .d    (spi_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    yadan_spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_scs (
        .clk  (clk),
        .rst  (rst),
        .d    (spi_scs),
        .rise (scs_rise),
        .fall (scs_fall)
    );

    // sdi goes through the same depth as sck so a rise pulse sees the bit the master set up
    always_ff @(posedge clk) begin
        if (!rst) sdi_sr <= '0;
        else      sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], spi_sdi};
    end

    assign sdi_sync = sdi_sr[SYNC_STAGES-1];
    assign last     = cnt == CW'(DATA_WIDTH - 1);
    assign rx_word  = {shift_rx, sdi_sync};
    assign write    = tx_valid && !hold_full;
    assign tx_ready = ~hold_full;
    assign busy     = state == ST_ACTIVE;
    assign spi_sdo  = (state == ST_ACTIVE) ? shifter[DATA_WIDTH-1] : 1'b1;

    // frame state register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next;
    end

    // next state and per-cycle datapath strobes; a chip-select release beats any sck edge
    always_comb begin
        next      = state;
        load      = 1'b0;
        bit_in    = 1'b0;
        shift_out = 1'b0;
        abort     = 1'b0;
        if (state == ST_IDLE) begin
            next = scs_fall ? ST_ACTIVE : ST_IDLE;
            load = scs_fall;
        end else if (scs_rise) begin
            next  = ST_IDLE;
            abort = 1'b1;
        end else begin
            bit_in    = sck_rise;
            load      = sck_fall && cnt == '0;
            shift_out = sck_fall && cnt != '0;
        end
    end

    // bit counter and receive shifter; a completed word moves to the output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            shift_rx   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (abort) cnt <= '0;
            else if (bit_in) cnt <= last ? '0 : cnt + 1'b1;
            if (bit_in) shift_rx <= rx_word[DATA_WIDTH-2:0];
            if (bit_in && last) begin
                rx_data    <= rx_word;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid && !rx_ready;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // transmit shifter and holding register; a load sees the holding register as it was before any write
    always_ff @(posedge clk) begin
        if (!rst) begin
            shifter     <= IDLE_WORD;
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load) begin
                shifter     <= hold_full ? hold : IDLE_WORD;
                tx_underrun <= ~hold_full;
            end else if (shift_out) begin
                shifter <= shifter << 1;
            end
            if (write) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule
